chebyshev_saturation_pipe: RTL
==============================

// Module: chebyshev_saturation_pipe
// PURPOSE
//  Pipelined, multi-channel successor to the combinational Chebyshev saturator.
//  Narrows signed fixed-point samples from WL bits (I_BITS integer bits) to
//  BOUNDARY_BIT_POSITION integer bits, keeping all fraction bits.
//  Per sample it either saturates or wraps, and flags every overflow.
//  Sits between the recurrence datapath and the coefficient accumulator,
//  with valid/ready on both sides.
// PARAMETERS
//  WL                     12  input wordlength (signed, two's complement)
//  I_BITS                  6  input integer bits, sign included
//  BOUNDARY_BIT_POSITION   3  output integer bits, sign included; 1..I_BITS
//  CHANNELS                4  number of interleaved channels; >=1
//  CNT_W                  16  width of the overflow event counter
//  derived: F_BITS=WL-I_BITS; O_BITS=WL-(I_BITS-BOUNDARY_BIT_POSITION);
//           CH_W=max(1,$clog2(CHANNELS))
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         synchronous, active-high reset
//  in_valid     in   1         input sample valid
//  in_ready     out  1         block can accept input this cycle
//  in_data      in   WL        signed input sample
//  in_chan      in   CH_W      channel tag of input sample
//  in_wrap      in   1         1=wrap (truncate), 0=saturate; per sample
//  out_valid    out  1         output sample valid
//  out_ready    in   1         downstream accepts output
//  out_data     out  O_BITS    narrowed sample
//  out_chan     out  CH_W      channel tag, passed through unchanged
//  out_sat      out  1         input was outside output range (either mode)
//  clear_stats  in   1         synchronous clear of sat_count / sat_sticky
//  sat_count    out  CNT_W     overflow events seen at output, saturates at all-ones
//  sat_sticky   out  CHANNELS  per-channel sticky overflow flag
// BEHAVIOUR
//  Reset: out_valid=0; out_data/out_chan/out_sat=0; sat_count=0; sat_sticky=0;
//   internal valids=0; in_ready=1 in the first cycle after reset.
//  Mid-operation reset drops all in-flight samples; no output handshake in that cycle.
//  Range: output represents [-2^(B-1), 2^(B-1)-2^-F_BITS], where B=BOUNDARY_BIT_POSITION.
//   Overflow: in_data[WL-1:O_BITS-1] not all equal (exact test; -2^(B-1) is legal).
//  Saturate mode on overflow: negative in -> {1'b1,{O_BITS-1{1'b0}}};
//   positive in -> {1'b0,{O_BITS-1{1'b1}}}.
//  Wrap mode, or no overflow: out_data = in_data[O_BITS-1:0].
//  Pipeline: S1 registers data, chan, wrap and overflow; S2 registers the result.
//   Latency is exactly 2 cycles from input handshake to out_valid when unstalled.
//   Throughput is 1 sample per cycle.
//  Flow control:
//   en2 = ~out_valid | out_ready; en1 = ~s1_valid | en2; in_ready = en1.
//   On en2, S2 takes S1 (or empties it). On en1, S1 takes input if in_valid.
//   in_ready is combinational from out_ready; no other comb in->out path.
//   out_data/out_chan/out_sat hold stable while out_valid & ~out_ready.
//   Samples are never dropped or duplicated; order is preserved.
//  Stats: an event is an output handshake (out_valid & out_ready) with out_sat=1.
//   On an event, sat_count increments (holds at 2^CNT_W-1) and sat_sticky[out_chan] is set.
//   out_chan >= CHANNELS: counts, but no sticky bit is set.
//   clear_stats with an event in the same cycle: count=1 and only that
//   channel's sticky bit is set. clear_stats alone: all stats go to 0 next cycle.
// TESTING  (defaults: WL=12, I_BITS=6, B=3, so O_BITS=9)
//  Pass-through: 0x0A3 (2.546875), sat mode -> out 0x0A3, out_sat=0, 2-cycle latency.
//  Saturation: 0x48E -> 0x0FF; 0xC8E -> 0x100; both out_sat=1; sat_count=2.
//  Boundaries: 0xF00 (-4.0) -> 0x100, out_sat=0; 0x100 (+4.0) -> 0x0FF, out_sat=1;
//   0x0FF -> 0x0FF, out_sat=0.
//  Wrap: 0x48E with in_wrap=1 -> 0x08E, out_sat=1; count increments, sticky set.
//  Backpressure: stream 8 tagged samples at random out_ready duty.
//   Every sample appears exactly once, in order; outputs stable during stalls;
//   in_ready=0 only when both stages are full and out_ready=0.
//  Stats and reset: clear_stats on an event cycle -> sat_count=1; counter at
//   0xFFFF plus an event stays 0xFFFF; rst mid-stream -> out_valid=0 next cycle,
//   stats 0.

Source files
------------

// File: rtl/chebyshev_saturation_pipe.sv
// Two-stage valid/ready pipeline that narrows signed fixed-point samples to fewer
// integer bits, saturating or wrapping per sample, with overflow statistics.
module chebyshev_saturation_pipe #(
  parameter int WL                    = 12,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  parameter int CHANNELS              = 4,
  parameter int CNT_W                 = 16,
  localparam int O_BITS = WL - (I_BITS - BOUNDARY_BIT_POSITION),
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WL-1:0]       in_data,
  input  logic [CH_W-1:0]     in_chan,
  input  logic                in_wrap,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [O_BITS-1:0]   out_data,
  output logic [CH_W-1:0]     out_chan,
  output logic                out_sat,
  input  logic                clear_stats,
  output logic [CNT_W-1:0]    sat_count,
  output logic [CHANNELS-1:0] sat_sticky
);

  localparam logic [O_BITS-1:0] SAT_POS = {1'b0, {(O_BITS-1){1'b1}}};
  localparam logic [O_BITS-1:0] SAT_NEG = {1'b1, {(O_BITS-1){1'b0}}};

  logic en1, en2, sat_event;
  logic [WL-O_BITS:0] in_top;
  logic               in_ovf;
  logic [O_BITS-1:0]  result;

  logic                s1_valid_q, s1_valid_d;
  logic [O_BITS-1:0]   s1_data_q, s1_data_d;
  logic                s1_sign_q, s1_sign_d;
  logic [CH_W-1:0]     s1_chan_q, s1_chan_d;
  logic                s1_wrap_q, s1_wrap_d;
  logic                s1_ovf_q, s1_ovf_d;

  logic                out_valid_q, out_valid_d;
  logic [O_BITS-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_chan_q, out_chan_d;
  logic                out_sat_q, out_sat_d;
  logic [CNT_W-1:0]    sat_count_q, sat_count_d;
  logic [CHANNELS-1:0] sat_sticky_q, sat_sticky_d;

  // Sample fits iff every bit from the MSB down to the new sign bit agrees.
  assign in_top = in_data[WL-1:O_BITS-1];
  assign in_ovf = ~((&in_top) | ~(|in_top));

  always_comb begin
    en2 = ~out_valid_q | out_ready;
    en1 = ~s1_valid_q | en2;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sign_d  = s1_sign_q;
    s1_chan_d  = s1_chan_q;
    s1_wrap_d  = s1_wrap_q;
    s1_ovf_d   = s1_ovf_q;
    if (en1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data[O_BITS-1:0];
        s1_sign_d = in_data[WL-1];
        s1_chan_d = in_chan;
        s1_wrap_d = in_wrap;
        s1_ovf_d  = in_ovf;
      end
    end

    result = s1_data_q;
    if (s1_ovf_q && !s1_wrap_q) begin
      result = s1_sign_q ? SAT_NEG : SAT_POS;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sat_d   = out_sat_q;
    if (en2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = result;
        out_chan_d = s1_chan_q;
        out_sat_d  = s1_ovf_q;
      end
    end

    // A clear in the same cycle as an event leaves just that event recorded.
    sat_event    = out_valid_q & out_ready & out_sat_q;
    sat_count_d  = clear_stats ? '0 : sat_count_q;
    sat_sticky_d = clear_stats ? '0 : sat_sticky_q;
    if (sat_event) begin
      if (clear_stats) begin
        sat_count_d = CNT_W'(1);
      end else if (sat_count_q != '1) begin
        sat_count_d = sat_count_q + CNT_W'(1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (out_chan_q == CH_W'(i)) begin
          sat_sticky_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_sign_q    <= 1'b0;
      s1_chan_q    <= '0;
      s1_wrap_q    <= 1'b0;
      s1_ovf_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_sat_q    <= 1'b0;
      sat_count_q  <= '0;
      sat_sticky_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_sign_q    <= s1_sign_d;
      s1_chan_q    <= s1_chan_d;
      s1_wrap_q    <= s1_wrap_d;
      s1_ovf_q     <= s1_ovf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_sat_q    <= out_sat_d;
      sat_count_q  <= sat_count_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign in_ready   = en1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;
  assign out_sat    = out_sat_q;
  assign sat_count  = sat_count_q;
  assign sat_sticky = sat_sticky_q;

endmodule
